// File: rtl/mul_div_if.sv
// mul_div_if: start/busy/done handshake, operands and HI/LO results of the multiply/divide unit
interface mul_div_if #(parameter int WIDTH = 32);
  logic start;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b;
  logic flush;
  logic ready, busy, done, div_zero;
  logic [WIDTH-1:0] hi, lo;
  modport master(output start, op, a, b, flush, input ready, busy, done, div_zero, hi, lo);
  modport slave(input start, op, a, b, flush, output ready, busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned MULT/DIV with architectural HI/LO and MTHI/MTLO writes
module mul_div_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  mul_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, dz, accept, last, sa, sb;
  logic [WIDTH-1:0] acc, q, m, hi, lo, acc_nx, q_nx, quo, rem;
  logic [WIDTH:0] mul_sum, rem_s, diff;
  logic [2*WIDTH-1:0] prod;
  assign accept = bus.start && !bus.flush && state != BUSY;
  assign last = state == BUSY && cnt == CW'(WIDTH-1);
  // a zero divisor keeps the dividend unsigned so the core naturally returns hi=a, lo=all ones
  assign sa = !bus.op[0] && bus.a[WIDTH-1] && !(bus.op[1] && bus.b == '0);
  assign sb = !bus.op[0] && bus.b[WIDTH-1];
  always_comb begin
    mul_sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    rem_s = {acc, q[WIDTH-1]};
    diff = rem_s - {1'b0, m};
    acc_nx = is_div ? (diff[WIDTH] ? rem_s[WIDTH-1:0] : diff[WIDTH-1:0]) : mul_sum[WIDTH:1];
    q_nx = is_div ? {q[WIDTH-2:0], !diff[WIDTH]} : {mul_sum[0], q[WIDTH-1:1]};
    prod = neg_q ? -{acc_nx, q_nx} : {acc_nx, q_nx};
    quo = neg_q ? -q_nx : q_nx;
    rem = neg_r ? -acc_nx : acc_nx;
  end
  always_comb begin
    state_nx = IDLE;
    if (state == BUSY) begin
      if (bus.flush) state_nx = IDLE;
      else if (last) state_nx = DONE;
      else state_nx = BUSY;
    end else if (accept) state_nx = bus.op[2] ? DONE : BUSY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      acc <= '0;
      q <= '0;
      m <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= '0;
        is_div <= bus.op[1];
        neg_q <= sa ^ sb;
        neg_r <= sa;
        dz <= bus.op[2:1] == 2'b01 && bus.b == '0;
        acc <= '0;
        q <= sa ? -bus.a : bus.a;
        m <= sb ? -bus.b : bus.b;
        if (bus.op == 3'b100) hi <= bus.a;
        if (bus.op == 3'b101) lo <= bus.a;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nx;
        q <= q_nx;
        if (last && !bus.flush) begin
          hi <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
          lo <= is_div ? quo : prod[WIDTH-1:0];
        end
      end
    end
  assign bus.ready = state != BUSY;
  assign bus.busy = state == BUSY;
  assign bus.done = state == DONE;
  assign bus.div_zero = state == DONE && dz;
  assign bus.hi = hi;
  assign bus.lo = lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  int tests = 0, fails = 0;
  mul_div_if #(.WIDTH(W)) bus();
  mul_div_unit #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {logic [2:0] op; logic [31:0] a, b, hi, lo; logic dz;} vec_t;
  vec_t vecs [0:10] = '{
    '{3'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0},
    '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0},
    '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0},
    '{3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
    '{3'd3, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0},
    '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0},
    '{3'd3, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1},
    '{3'd2, 32'h6, 32'h3, 32'h0, 32'h2, 1'b0},
    '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0},
    '{3'd2, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0},
    '{3'd2, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1}
  };

  function automatic void model(input logic [2:0] op, input logic [31:0] a, b,
                                inout logic [31:0] hi, lo, output logic dz);
    logic [63:0] p;
    longint sq, sr;
    dz = 1'b0;
    case (op)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; end
      3'd2, 3'd3:
        if (b == 0) begin hi = a; lo = '1; dz = 1'b1; end
        else if (op == 3'd2) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          lo = sq[31:0];
          hi = sr[31:0];
        end else begin lo = a / b; hi = a % b; end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h0;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // called at a negedge with the unit ready; returns at the negedge where done is seen
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, output int edges, output int busy_cyc);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom();
    bus.b = $urandom();
    edges = 1;
    busy_cyc = 0;
    while (!bus.done && edges < 100) begin
      busy_cyc += int'(bus.busy);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.ready, bus.busy, bus.done, bus.div_zero} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 1000", {bus.ready, bus.busy, bus.done, bus.div_zero});
    end
    tests++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      fails++;
      $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int e, bc;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, e, bc);
      tests++;
      if (e !== W + 1 || bc !== W) begin
        fails++;
        $display("FAIL dir%0d_latency: got edges=%0d busy=%0d expected edges=%0d busy=%0d", i, e, bc, W + 1, W);
      end
      tests++;
      if ({bus.hi, bus.lo, bus.div_zero} !== {vecs[i].hi, vecs[i].lo, vecs[i].dz}) begin
        fails++;
        $display("FAIL dir%0d_result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                 i, bus.hi, bus.lo, bus.div_zero, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      end
    end
  endtask

  task automatic test_random();
    int e, bc;
    logic [2:0] op;
    logic [31:0] a, b, eh, el;
    logic edz;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a = pick();
      b = pick();
      eh = bus.hi;
      el = bus.lo;
      model(op, a, b, eh, el, edz);
      issue(op, a, b, e, bc);
      tests++;
      if (e !== (op[2] ? 1 : W + 1)) begin
        fails++;
        $display("FAIL rnd%0d_latency: got %0d expected %0d", i, e, op[2] ? 1 : W + 1);
      end
      tests++;
      if ({bus.hi, bus.lo, bus.div_zero} !== {eh, el, edz}) begin
        fails++;
        $display("FAIL rnd%0d_op%0d a=%h b=%h: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                 i, op, a, b, bus.hi, bus.lo, bus.div_zero, eh, el, edz);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2, e3, b1, b2, b3;
    logic [31:0] lo0;
    issue(3'd4, 32'hAAAA5555, 32'h0, e1, b1);
    lo0 = bus.lo;
    tests++;
    if (bus.hi !== 32'hAAAA5555 || bus.lo !== lo0 || bus.div_zero !== 1'b0) begin
      fails++;
      $display("FAIL mthi: got hi=%h dz=%b expected hi=aaaa5555 dz=0", bus.hi, bus.div_zero);
    end
    issue(3'd5, 32'h1234, 32'h0, e2, b2);
    issue(3'd6, 32'h5555, 32'h7777, e3, b3);
    tests++;
    if ({e1, e2, e3} !== {32'd1, 32'd1, 32'd1} || b1 + b2 + b3 !== 0) begin
      fails++;
      $display("FAIL b2b_timing: got edges=%0d,%0d,%0d busy=%0d expected 1,1,1 busy=0", e1, e2, e3, b1 + b2 + b3);
    end
    tests++;
    if ({bus.hi, bus.lo} !== {32'hAAAA5555, 32'h1234}) begin
      fails++;
      $display("FAIL b2b_hilo: got hi=%h lo=%h expected hi=aaaa5555 lo=00001234", bus.hi, bus.lo);
    end
    @(negedge clk);
    tests++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
      fails++;
      $display("FAIL done_pulse: got %b expected 100", {bus.ready, bus.busy, bus.done});
    end
  endtask

  task automatic flush_at(input int iter, input string name);
    int e, b, dn;
    issue(3'd4, 32'hCAFEF00D, 32'h0, e, b);
    issue(3'd5, 32'hCAFEF00D, 32'h0, e, b);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = $urandom(); bus.b = $urandom();
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (iter - 1) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    tests++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100 || {bus.hi, bus.lo} !== {2{32'hCAFEF00D}}) begin
      fails++;
      $display("FAIL %s_state: got rbd=%b hi=%h lo=%h expected rbd=100 hi=lo=cafef00d",
               name, {bus.ready, bus.busy, bus.done}, bus.hi, bus.lo);
    end
    dn = 0;
    repeat (W + 4) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    tests++;
    if (dn !== 0 || {bus.hi, bus.lo} !== {2{32'hCAFEF00D}}) begin
      fails++;
      $display("FAIL %s_quiet: got done_count=%0d hi=%h lo=%h expected 0 and cafef00d", name, dn, bus.hi, bus.lo);
    end
  endtask

  task automatic test_flush();
    flush_at(10, "flush_iter10");
    flush_at(W, "flush_last");
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd4; bus.a = 32'h1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    tests++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.hi !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL start_flush: got bd=%b hi=%h expected bd=00 hi=cafef00d", {bus.busy, bus.done}, bus.hi);
    end
  endtask

  task automatic test_reset_mid();
    int e, b;
    issue(3'd4, 32'hCAFEF00D, 32'h0, e, b);
    issue(3'd5, 32'hCAFEF00D, 32'h0, e, b);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h3; bus.b = 32'h5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100 || {bus.hi, bus.lo} !== 64'h0) begin
      fails++;
      $display("FAIL reset_mid: got rbd=%b hi=%h lo=%h expected rbd=100 hi=lo=0",
               {bus.ready, bus.busy, bus.done}, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd3, 32'd7, 32'd2, e, b);
    tests++;
    if ({bus.hi, bus.lo} !== {32'd1, 32'd3} || e !== W + 1) begin
      fails++;
      $display("FAIL after_reset_divu: got hi=%h lo=%h edges=%0d expected hi=1 lo=3 edges=%0d", bus.hi, bus.lo, e, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit for the MIPS execute stage. It sits beside the combinational ALU.
- Performs signed and unsigned MULT/DIV iteratively and owns the architectural HI/LO registers, including MTHI/MTLO writes.
- Uses a start/busy/done handshake so the pipeline controller can stall on busy.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; must be even and ≥4.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when ready=1
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- a  in  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO source)
- b  in  WIDTH  operand rt (divisor / multiplier)
- flush  in  1  abort the in-flight operation (exception/branch flush)
- ready  out  1  unit can accept start this cycle
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: result written to HI/LO
- div_zero  out  1  qualifies done; the completed DIV/DIVU had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, hi=lo=0, busy=0, done=0, div_zero=0, ready=1. Counters and working registers are cleared.
- States are IDLE, BUSY and DONE. ready=1 in IDLE and DONE; busy=1 only in BUSY; done=1 only in DONE.
- Accept (start=1 and ready=1 at edge E0):
  - MULT/MULTU/DIV/DIVU: latch the operands and the sign info, then go to BUSY with iteration counter=0.
  - MTHI/MTLO: write a to hi or lo at E0, then go to DONE. div_zero=0 and the other register is unchanged.
  - op 11x: go to DONE and change nothing.
- start while in BUSY is ignored; the controller must hold it.
- BUSY performs one iteration per edge, E1..E_WIDTH, exactly WIDTH iterations.
  - At E_WIDTH, HI/LO are written and the unit goes to DONE.
  - done is high during the cycle after E_WIDTH. Latency from the accept edge to the result is WIDTH+1 edges.
- DONE: the next edge goes to IDLE, or accepts a new start back-to-back (done deasserts and busy rises).
- Signed handling (MULT, DIV): operands are converted to magnitudes, the unsigned core runs, then signs are applied.
  - Product sign is a[W-1]^b[W-1].
  - Quotient sign is a[W-1]^b[W-1]; remainder sign follows the dividend.
- MULT/MULTU use a shift-add core with a 2*WIDTH product: {hi,lo} = full product, exact, no overflow. MIN*MIN gives 2^(2W-2).
- DIV/DIVU use a restoring core: lo=quotient, hi=remainder, truncation toward zero.
- Divide by zero (b==0, either signedness): lo = all ones, hi = a (unmodified), div_zero=1 during done. The full WIDTH cycles are still taken.
- Signed MIN / -1: lo = MIN (wraps), hi = 0, div_zero=0.
- flush=1 in BUSY: return to IDLE at the next edge. hi/lo are unchanged, no done pulse is produced, and ready=1 in the following cycle.
- flush in IDLE/DONE has no effect on hi/lo; a start and flush in the same cycle means the start is dropped.
- flush has priority over iteration completion at E_WIDTH.
- Reset mid-operation: immediate return to reset values; no partial result is written.
- Operands a/b may change after the accept edge without affecting the result.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFD(-3), b=5 -> done exactly 33 edges after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for 32 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same operands via MULT -> hi=0, lo=1.
- DIV a=-7(0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1 with done. The next DIV 6/3 -> div_zero=0, lo=2, hi=0.
- MTHI a=0xAAAA5555 then MTLO a=0x1234, issued back-to-back in DONE -> done on consecutive cycles; hi=0xAAAA5555, lo=0x1234; busy never asserted.
- MULT started with hi=lo=0xCAFEF00D, flush at iteration 10 -> no done, hi/lo unchanged, ready=1 the next cycle. The same again with rst_n pulsed low mid-BUSY -> hi=lo=0 and state IDLE asynchronously.
